// File: rtl/note_sequencer_if.sv
// rtl/note_sequencer_if.sv - control, table-write and tone-output bundle of the note sequencer
interface note_sequencer_if;
    logic        start;
    logic        stop;
    logic        loop;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [7:0]  wr_data;
    // 16 bits wide: the C4..F4 half-periods (up to 47777) do not fit in 15
    logic [15:0] value;
    logic        enable;
    logic        busy;
    logic        done;
    logic [3:0]  note_idx;

    modport master (
        output start, stop, loop, wr_en, wr_addr, wr_data,
        input  value, enable, busy, done, note_idx
    );

    modport slave (
        input  start, stop, loop, wr_en, wr_addr, wr_data,
        output value, enable, busy, done, note_idx
    );
endinterface

// File: rtl/note_sequencer.sv
// rtl/note_sequencer.sv - 16-entry note table player driving the square-wave tone generator
module note_sequencer #(
    parameter int TICK_DIV   = 1_250_000,
    parameter int GAP_CYCLES = 250_000
) (
    input logic             i_clk,
    input logic             i_rst,
    note_sequencer_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_PLAY, S_GAP, S_END} state_t;

    localparam logic [20:0] TICK_LAST = 21'(TICK_DIV - 1);
    localparam logic [20:0] GAP_LAST  = 21'(GAP_CYCLES - 1);
    localparam bit          HAS_GAP   = (GAP_CYCLES != 0);

    state_t      r_state;
    logic [7:0]  r_mem [16];
    logic [7:0]  r_rdata;
    logic [3:0]  r_addr;
    logic [3:0]  r_dur;
    logic [3:0]  r_tick;
    logic [20:0] r_div;
    logic        r_restart;
    logic [15:0] r_value;
    logic        r_enable;
    logic        r_busy;
    logic        r_done;

    logic        w_mem_we;
    logic [3:0]  w_rd_addr;
    logic        w_note_last;
    logic        w_gap_last;
    logic        w_advance;
    logic [15:0] w_pitch_value;
    logic        w_pitch_on;

    always_comb begin
        w_pitch_on = 1'b1;
        case (r_rdata[7:4])
            4'd1:    w_pitch_value = 16'd47777;
            4'd2:    w_pitch_value = 16'd42565;
            4'd3:    w_pitch_value = 16'd37921;
            4'd4:    w_pitch_value = 16'd35793;
            4'd5:    w_pitch_value = 16'd31888;
            4'd6:    w_pitch_value = 16'd28408;
            4'd7:    w_pitch_value = 16'd25309;
            4'd8:    w_pitch_value = 16'd23888;
            default: begin
                w_pitch_value = 16'd0;
                w_pitch_on    = 1'b0;
            end
        endcase
    end

    assign w_mem_we    = bus.wr_en && (r_state == S_IDLE) && !i_rst;
    // The read is issued one cycle ahead so the entry is ready during FETCH
    assign w_rd_addr   = (r_state == S_IDLE || r_state == S_END) ? 4'd0 : r_addr + 4'd1;
    assign w_note_last = (r_state == S_PLAY) && (r_div == TICK_LAST) && (r_tick == r_dur - 4'd1);
    assign w_gap_last  = (r_state == S_GAP) && (r_div == GAP_LAST);
    assign w_advance   = (w_note_last && !HAS_GAP) || w_gap_last;

    always_ff @(posedge i_clk) begin
        if (w_mem_we) begin
            r_mem[bus.wr_addr] <= bus.wr_data;
        end
        r_rdata <= r_mem[w_rd_addr];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_addr    <= 4'd0;
            r_dur     <= 4'd0;
            r_tick    <= 4'd0;
            r_div     <= 21'd0;
            r_restart <= 1'b0;
            r_value   <= 16'd0;
            r_enable  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (bus.stop) begin
                r_state  <= S_IDLE;
                r_value  <= 16'd0;
                r_enable <= 1'b0;
                r_busy   <= 1'b0;
            end else if (w_advance) begin
                // Stepping past entry 15 ends the song like an end marker would
                if (r_addr == 4'd15) begin
                    r_state   <= S_END;
                    r_restart <= bus.loop;
                    r_done    <= !bus.loop;
                end else begin
                    r_state <= S_FETCH;
                    r_addr  <= r_addr + 4'd1;
                end
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.start) begin
                            r_state <= S_FETCH;
                            r_addr  <= 4'd0;
                            r_busy  <= 1'b1;
                        end
                    end
                    S_FETCH: begin
                        if (r_rdata[3:0] == 4'd0) begin
                            r_state   <= S_END;
                            r_restart <= bus.loop && (r_addr != 4'd0);
                            r_done    <= !(bus.loop && (r_addr != 4'd0));
                        end else begin
                            r_state  <= S_PLAY;
                            r_dur    <= r_rdata[3:0];
                            r_value  <= w_pitch_value;
                            r_enable <= w_pitch_on;
                            r_div    <= 21'd0;
                            r_tick   <= 4'd0;
                        end
                    end
                    S_PLAY: begin
                        if (r_div == TICK_LAST) begin
                            r_div <= 21'd0;
                            if (w_note_last) begin
                                r_state  <= S_GAP;
                                r_enable <= 1'b0;
                            end else begin
                                r_tick <= r_tick + 4'd1;
                            end
                        end else begin
                            r_div <= r_div + 21'd1;
                        end
                    end
                    S_GAP: begin
                        r_div <= r_div + 21'd1;
                    end
                    S_END: begin
                        if (r_restart) begin
                            r_state <= S_FETCH;
                            r_addr  <= 4'd0;
                        end else begin
                            r_state  <= S_IDLE;
                            r_value  <= 16'd0;
                            r_enable <= 1'b0;
                            r_busy   <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.value    = r_value;
    assign bus.enable   = r_enable;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.note_idx = r_addr;
endmodule
